// File: rtl/pcs_bip_pkg.sv
// pcs_bip_pkg: shared constants, BIP8 parity masks and checker state type for the 100GBASE-R PCS.
package pcs_bip_pkg;
    localparam int NB_BLOCK  = 66;
    localparam int NB_BIP    = 8;
    localparam int BIP3_BYTE = 3;
    localparam int BIP7_BYTE = 7;
    // Payload bit j of every byte feeds bip[j]; sync-header bits 0/1 also feed bip[3]/bip[4].
    localparam logic [NB_BLOCK-1:0] BIP_MASK [0:NB_BIP-1] = '{
        {64'h0101_0101_0101_0101, 2'b00},
        {64'h0202_0202_0202_0202, 2'b00},
        {64'h0404_0404_0404_0404, 2'b00},
        {64'h0808_0808_0808_0808, 2'b01},
        {64'h1010_1010_1010_1010, 2'b10},
        {64'h2020_2020_2020_2020, 2'b00},
        {64'h4040_4040_4040_4040, 2'b00},
        {64'h8080_8080_8080_8080, 2'b00}
    };
    typedef enum logic {WAIT_AM, ACCUM} bip_state_t;
endpackage

// File: rtl/bip8_parity.sv
// bip8_parity: combinational bit-interleaved parity of one 66b block.
module bip8_parity
    import pcs_bip_pkg::*;
(
    input  logic [NB_BLOCK-1:0] i_data,
    output logic [NB_BIP-1:0]   o_bip
);
    for (genvar j = 0; j < NB_BIP; j++) begin : g_bit
        assign o_bip[j] = ^(i_data & BIP_MASK[j]);
    end
endmodule

// File: rtl/am_bip_calculator.sv
// am_bip_calculator: per-lane BIP8 accumulation between alignment markers with received/calculated compare strobe.
module am_bip_calculator
    import pcs_bip_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic                i_am_flag,
    input  logic [NB_BLOCK-1:0] i_data,
    output logic                o_match,
    output logic [NB_BIP-1:0]   o_received_bip,
    output logic [NB_BIP-1:0]   o_calculated_bip,
    output logic                o_bip7_error
);
    bip_state_t        state;
    logic [NB_BIP-1:0] accum;
    logic [NB_BIP-1:0] block_bip;
    logic [NB_BIP-1:0] bip3;
    logic [NB_BIP-1:0] bip7;

    assign bip3 = i_data[2+8*BIP3_BYTE +: NB_BIP];
    assign bip7 = i_data[2+8*BIP7_BYTE +: NB_BIP];

    bip8_parity u_parity (
        .i_data (i_data),
        .o_bip  (block_bip)
    );

    // The AM's own parity seeds the next interval, so a capture and a restart share one beat.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= WAIT_AM;
            accum            <= '0;
            o_match          <= 1'b0;
            o_received_bip   <= '0;
            o_calculated_bip <= '0;
            o_bip7_error     <= 1'b0;
        end else begin
            o_match <= 1'b0;
            if (!i_enable) begin
                state <= WAIT_AM;
                accum <= '0;
            end else if (i_valid) begin
                if (state == WAIT_AM) begin
                    if (i_am_flag) begin
                        accum <= block_bip;
                        state <= ACCUM;
                    end
                end else if (i_am_flag) begin
                    o_calculated_bip <= accum;
                    o_received_bip   <= bip3;
                    o_bip7_error     <= bip7 != ~bip3;
                    o_match          <= 1'b1;
                    accum            <= block_bip;
                end else begin
                    accum <= accum ^ block_bip;
                end
            end
        end
    end
endmodule

// File: tb/tb_am_bip_calculator.sv
// tb_am_bip_calculator: directed AM/data streams with a scoreboard of hand-computed BIP compares.
module tb_am_bip_calculator;
    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic        i_am_flag;
    logic [65:0] i_data;
    logic        o_match;
    logic [7:0]  o_received_bip;
    logic [7:0]  o_calculated_bip;
    logic        o_bip7_error;

    typedef struct packed {
        logic [7:0] rx;
        logic [7:0] calc;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    am_bip_calculator dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_enable         (i_enable),
        .i_valid          (i_valid),
        .i_am_flag        (i_am_flag),
        .i_data           (i_data),
        .o_match          (o_match),
        .o_received_bip   (o_received_bip),
        .o_calculated_bip (o_calculated_bip),
        .o_bip7_error     (o_bip7_error)
    );

    always #5 clk = ~clk;

    // Lane-0 marker bytes XOR to FF, so a consistent AM (BIP7 = ~BIP3) always has parity 8'h10.
    function automatic logic [65:0] am_blk(input logic [7:0] b3, input logic [7:0] b7);
        return {b7, 8'hDE, 8'h97, 8'h3E, b3, 8'h21, 8'h68, 8'hC1, 2'b10};
    endfunction

    function automatic logic [65:0] dblk(input logic [63:0] p);
        return {p, 2'b01};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic am, input logic [65:0] d);
        i_enable  = en;
        i_valid   = v;
        i_am_flag = am;
        i_data    = d;
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_am_flag = 1'b0;
    endtask

    task automatic zeros(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0, dblk(64'h0));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b1, am_blk(8'hAA, 8'hAA));
    endtask

    task automatic expect_cmp(input logic [7:0] rx, input logic [7:0] calc, input logic err);
        sb.push_back('{rx: rx, calc: calc, err: err});
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_match"}, {31'b0, o_match}, 32'h0);
        chk({tag, "_rx"}, {24'b0, o_received_bip}, 32'h0);
        chk({tag, "_calc"}, {24'b0, o_calculated_bip}, 32'h0);
        chk({tag, "_bip7"}, {31'b0, o_bip7_error}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!i_reset && o_match) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_match: o_match=1 required 0 (rx %h calc %h)",
                         o_received_bip, o_calculated_bip);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_bip", {24'b0, o_received_bip}, {24'b0, mon_e.rx});
                chk("calc_bip", {24'b0, o_calculated_bip}, {24'b0, mon_e.calc});
                chk("bip7_err", {31'b0, o_bip7_error}, {31'b0, mon_e.err});
            end
        end
    end

    initial begin
        i_reset   = 1'b1;
        i_enable  = 1'b0;
        i_valid   = 1'b0;
        i_am_flag = 1'b0;
        i_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        i_reset = 1'b0;
        // Clean interval: 8'h10 ^ 16383 sync-01 blocks (odd count toggles bip3) = 8'h18.
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h00, 8'hFF));
        zeros(16383);
        expect_cmp(8'h18, 8'h18, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h18, 8'hE7));
        // One flipped i_data[10] inverts calc bit 0.
        zeros(100);
        drive(1'b1, 1'b1, 1'b0, dblk(64'h100));
        zeros(16282);
        expect_cmp(8'h18, 8'h19, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h18, 8'hE7));
        // Bad BIP7; this AM's parity is E7 ^ 10 = F7.
        zeros(3);
        expect_cmp(8'h18, 8'h18, 1'b1);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h18, 8'h00));
        // Enable dropped on the AM beat, next AM only rearms.
        zeros(2);
        drive(1'b0, 1'b1, 1'b1, am_blk(8'h18, 8'hE7));
        zeros(1);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h55, 8'hAA));
        zeros(1);
        expect_cmp(8'h18, 8'h18, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h18, 8'hE7));
        // 10 ^ (A5^08) ^ (3C^08) ^ (0F^08) = 8E, with and without gaps.
        drive(1'b1, 1'b1, 1'b0, dblk(64'h0000_0000_0000_00A5));
        drive(1'b1, 1'b1, 1'b0, dblk(64'h3C00_0000_0000_0000));
        drive(1'b1, 1'b1, 1'b0, dblk(64'h0000_0000_0F00_0000));
        expect_cmp(8'h8E, 8'h8E, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h8E, 8'h71));
        idle(5);
        drive(1'b1, 1'b1, 1'b0, dblk(64'h0000_0000_0000_00A5));
        idle(5);
        drive(1'b1, 1'b1, 1'b0, dblk(64'h3C00_0000_0000_0000));
        idle(5);
        drive(1'b1, 1'b1, 1'b0, dblk(64'h0000_0000_0F00_0000));
        idle(5);
        expect_cmp(8'h8E, 8'h8E, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h8E, 8'h71));
        // Reset mid-interval, then the first AM after reset only arms.
        zeros(2);
        i_reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, dblk(64'hFF));
        chk_zero_outputs("midreset");
        i_reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h00, 8'hFF));
        zeros(1);
        expect_cmp(8'h18, 8'h18, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h18, 8'hE7));
        // Back-to-back AMs: interval is just the previous AM's parity.
        expect_cmp(8'h10, 8'h10, 1'b0);
        drive(1'b1, 1'b1, 1'b1, am_blk(8'h10, 8'hEF));
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drain", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
